// File: rtl/osd_pkg.sv
// osd_pkg: op encodings, OSD command bytes and FSM state type shared by the
// OSD SPI controller and its testbench.
package osd_pkg;

  typedef enum logic [1:0] {
    OP_DISABLE = 2'b00,
    OP_ENABLE  = 2'b01,
    OP_WRITE   = 2'b10,
    OP_CLEAR   = 2'b11
  } osd_op_e;

  localparam logic [7:0] CMD_ENABLE  = 8'h41;
  localparam logic [7:0] CMD_DISABLE = 8'h40;
  localparam logic [7:0] CMD_WRITE   = 8'h20;

  localparam int unsigned OSD_LINE_BYTES = 256;

  typedef enum logic [2:0] {
    StIdle,
    StGrant,
    StSetup,
    StShiftLo,
    StShiftHi,
    StHold,
    StGap
  } osd_state_e;

  // Command byte for an op; write and clear both address a line.
  function automatic logic [7:0] osd_cmd(input osd_op_e op, input logic [2:0] line);
    logic [7:0] cmd;
    case (op)
      OP_DISABLE: cmd = CMD_DISABLE;
      OP_ENABLE:  cmd = CMD_ENABLE;
      default:    cmd = CMD_WRITE | {5'b00000, line};
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/osd_spi_shifter.sv
// osd_spi_shifter: SCK half-period divider plus MSB-first byte serializer.
// The controller loads a byte with load_i, advances bits with shift_i and
// learns from last_o that the current bit is the final one of the byte.
module osd_spi_shifter #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       run_i,
  input  logic       load_i,
  input  logic       shift_i,
  input  logic [7:0] byte_i,
  output logic       tick_o,
  output logic       last_o,
  output logic       msb_d_o
);

  logic [15:0] div_q, div_d;
  logic [7:0]  sh_q, sh_d;
  logic [2:0]  cnt_q, cnt_d;

  assign tick_o  = run_i && (div_q == 16'(CLK_DIV - 1));
  assign last_o  = (cnt_q == 3'd0);
  // Next-cycle output bit, so the controller can register spi_do in step with SCK.
  assign msb_d_o = sh_d[7];

  // Divider restarts whenever the controller is not in a timed phase.
  always_comb begin
    div_d = (run_i && !tick_o) ? div_q + 16'd1 : 16'd0;
    sh_d  = sh_q;
    cnt_d = cnt_q;
    if (load_i) begin
      sh_d  = byte_i;
      cnt_d = 3'd7;
    end else if (shift_i) begin
      sh_d  = {sh_q[6:0], 1'b0};
      cnt_d = cnt_q - 3'd1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      div_q <= '0;
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      div_q <= div_d;
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/osd_spi_ctrl.sv
// osd_spi_ctrl: round-robin arbiter and frame FSM driving the OSD SPI port.
// Optional feature macro OSD_SPI_CLEAR_EN: when defined, op 11 sends a line
// of zero bytes; otherwise op 11 is acknowledged without an SPI frame.
module osd_spi_ctrl
  import osd_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned SS_GAP  = 8
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic [1:0] op0,
  input  logic [1:0] op1,
  input  logic [2:0] line0,
  input  logic [2:0] line1,
  output logic [1:0] gnt,
  output logic [1:0] done,
  output logic       busy,
  output logic       rd_en,
  output logic       rd_sel,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data0,
  input  logic [7:0] rd_data1,
  output logic       spi_sck,
  output logic       spi_ss,
  output logic       spi_do
);

  osd_state_e  state_q, state_d;
  osd_op_e     op_q, op_d;
  logic [2:0]  line_q, line_d;
  logic        sel_q, sel_d, last_q, last_d;
  logic [1:0]  gnt_q, gnt_d, done_q, done_d;
  logic        busy_q, busy_d, rd_en_q, rd_en_d, rd_vld_q, rd_vld_d;
  logic [7:0]  rd_addr_q, rd_addr_d, shadow_q, shadow_d;
  logic [8:0]  byte_cnt_q, byte_cnt_d;
  logic [15:0] gap_q, gap_d;
  logic        sck_q, sck_d, ss_q, ss_d, do_q, do_d;

  logic       sh_run, sh_load, sh_shift, sh_tick, sh_last, sh_msb_d;
  logic [7:0] sh_byte;
  logic       win, is_noop, has_payload;
  logic [8:0] frame_bytes;

`ifdef OSD_SPI_CLEAR_EN
  assign is_noop     = 1'b0;
  assign has_payload = (op_q == OP_WRITE) || (op_q == OP_CLEAR);
`else
  assign is_noop     = (op_q == OP_CLEAR);
  assign has_payload = (op_q == OP_WRITE);
`endif

  // Command byte plus, for line ops, one full line of payload.
  assign frame_bytes = has_payload ? 9'(OSD_LINE_BYTES) + 9'd1 : 9'd1;
  assign sh_run = (state_q == StSetup) || (state_q == StShiftLo) ||
                  (state_q == StShiftHi) || (state_q == StHold);

  osd_spi_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk_i   (clk_sys),
    .rst_ni  (reset_n),
    .run_i   (sh_run),
    .load_i  (sh_load),
    .shift_i (sh_shift),
    .byte_i  (sh_byte),
    .tick_o  (sh_tick),
    .last_o  (sh_last),
    .msb_d_o (sh_msb_d)
  );

  // Next-state, arbitration, payload prefetch and registered-output decode.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    line_d     = line_q;
    sel_d      = sel_q;
    last_d     = last_q;
    gnt_d      = 2'b00;
    done_d     = 2'b00;
    busy_d     = busy_q;
    rd_en_d    = 1'b0;
    rd_addr_d  = rd_addr_q;
    rd_vld_d   = rd_en_q;
    shadow_d   = shadow_q;
    byte_cnt_d = byte_cnt_q;
    gap_d      = gap_q;
    sh_load    = 1'b0;
    sh_shift   = 1'b0;
    sh_byte    = (op_q == OP_WRITE) ? shadow_q : 8'h00;
    win        = 1'b0;

    // Read data is valid exactly one cycle after the strobe.
    if (rd_vld_q) shadow_d = rd_sel ? rd_data1 : rd_data0;

    unique case (state_q)
      StIdle: begin
        busy_d = 1'b0;
        if (req != 2'b00) begin
          // On contention the requester not granted last wins.
          win     = (req == 2'b11) ? ~last_q : req[1];
          sel_d   = win;
          gnt_d   = win ? 2'b10 : 2'b01;
          op_d    = win ? osd_op_e'(op1) : osd_op_e'(op0);
          line_d  = win ? line1 : line0;
          busy_d  = 1'b1;
          state_d = StGrant;
        end
      end
      StGrant: begin
        last_d = sel_q;
        if (is_noop) begin
          done_d  = sel_q ? 2'b10 : 2'b01;
          state_d = StIdle;
        end else begin
          sh_load    = 1'b1;
          sh_byte    = osd_cmd(op_q, line_q);
          byte_cnt_d = 9'd1;
          state_d    = StSetup;
          if (op_q == OP_WRITE) begin
            rd_en_d   = 1'b1;
            rd_addr_d = 8'd0;
          end
        end
      end
      StSetup: if (sh_tick) state_d = StShiftLo;
      StShiftLo: if (sh_tick) state_d = StShiftHi;
      StShiftHi: begin
        if (sh_tick) begin
          if (!sh_last) begin
            sh_shift = 1'b1;
            state_d  = StShiftLo;
          end else if (byte_cnt_q < frame_bytes) begin
            // Starting payload byte k; prefetch byte k+1 while it shifts.
            sh_load    = 1'b1;
            byte_cnt_d = byte_cnt_q + 9'd1;
            state_d    = StShiftLo;
            if ((op_q == OP_WRITE) && (byte_cnt_q <= 9'd255)) begin
              rd_en_d   = 1'b1;
              rd_addr_d = byte_cnt_q[7:0];
            end
          end else begin
            state_d = StHold;
          end
        end
      end
      StHold: begin
        if (sh_tick) begin
          done_d  = sel_q ? 2'b10 : 2'b01;
          gap_d   = 16'd0;
          state_d = StGap;
        end
      end
      StGap: begin
        if (gap_q == 16'(SS_GAP - 1)) begin
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    sck_d = (state_d == StShiftHi);
    ss_d  = !((state_d == StSetup) || (state_d == StShiftLo) ||
              (state_d == StShiftHi) || (state_d == StHold));
    do_d  = ((state_d == StShiftLo) || (state_d == StShiftHi)) ? sh_msb_d : 1'b0;
  end

  // FSM and registered outputs; reset abandons any frame without a done pulse.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      op_q       <= OP_DISABLE;
      line_q     <= '0;
      sel_q      <= 1'b0;
      last_q     <= 1'b1;
      gnt_q      <= '0;
      done_q     <= '0;
      busy_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      rd_vld_q   <= 1'b0;
      shadow_q   <= '0;
      byte_cnt_q <= '0;
      gap_q      <= '0;
      sck_q      <= 1'b0;
      ss_q       <= 1'b1;
      do_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      line_q     <= line_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      rd_vld_q   <= rd_vld_d;
      shadow_q   <= shadow_d;
      byte_cnt_q <= byte_cnt_d;
      gap_q      <= gap_d;
      sck_q      <= sck_d;
      ss_q       <= ss_d;
      do_q       <= do_d;
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign busy    = busy_q;
  assign rd_en   = rd_en_q;
  assign rd_sel  = sel_q;
  assign rd_addr = rd_addr_q;
  assign spi_sck = sck_q;
  assign spi_ss  = ss_q;
  assign spi_do  = do_q;

endmodule

// File: tb/tb_osd_spi_ctrl.sv
// tb_osd_spi_ctrl: directed scenarios for osd_spi_ctrl with CLK_DIV=2, SS_GAP=8.
module tb_osd_spi_ctrl;

  localparam int unsigned CLK_DIV = 2;
  localparam int unsigned SS_GAP  = 8;
  localparam int          WR_BITS = 2056;
  localparam int          WR_LOW  = 2 * (2 * 2056 + 2);
  localparam int          EN_LOW  = 2 * (2 * 8 + 2);

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] req = 2'b00, op0 = 2'b00, op1 = 2'b00;
  logic [2:0] line0 = 3'd0, line1 = 3'd0;
  logic [7:0] rd_data0 = 8'hEE, rd_data1 = 8'hEE;
  logic [1:0] gnt, done;
  logic       busy, rd_en, rd_sel, spi_sck, spi_ss, spi_do;
  logic [7:0] rd_addr;

  int total = 0;
  int bad   = 0;

  osd_spi_ctrl #(
    .CLK_DIV (CLK_DIV),
    .SS_GAP  (SS_GAP)
  ) dut (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .req      (req),
    .op0      (op0),
    .op1      (op1),
    .line0    (line0),
    .line1    (line1),
    .gnt      (gnt),
    .done     (done),
    .busy     (busy),
    .rd_en    (rd_en),
    .rd_sel   (rd_sel),
    .rd_addr  (rd_addr),
    .rd_data0 (rd_data0),
    .rd_data1 (rd_data1),
    .spi_sck  (spi_sck),
    .spi_ss   (spi_ss),
    .spi_do   (spi_do)
  );

  always #5 clk_sys = ~clk_sys;

  // Payload source: data valid only in the cycle after a strobe, junk otherwise.
  initial begin
    logic       pend;
    logic [7:0] paddr;
    pend = 1'b0;
    paddr = 8'd0;
    forever begin
      @(posedge clk_sys);
      #1;
      rd_data0 = pend ? (paddr ^ 8'h3C) : 8'hEE;
      rd_data1 = pend ? (paddr ^ 8'hA5) : 8'hEE;
      pend  = rd_en;
      paddr = rd_addr;
    end
  end

  // Frame capture results.
  bit [7:0]   fr_bytes [0:256];
  int         fr_bits, fr_low, fr_gap, fr_rden, fr_selbad, fr_ngnt;
  logic [1:0] fr_gnt, fr_done;
  bit         fr_ok;

  // Watch one request/frame: grant, SS-low span, sampled bits, done at SS rise.
  task automatic capture_frame(input logic exp_sel, input bit drop);
    logic prev_sck;
    fr_bits = 0; fr_low = 0; fr_gap = 0; fr_rden = 0; fr_selbad = 0; fr_ngnt = 0;
    fr_gnt = 2'b00; fr_done = 2'b00; fr_ok = 1'b0;
    for (int i = 0; i < 257; i++) fr_bytes[i] = 8'h00;
    prev_sck = 1'b0;
    for (int n = 0; n < 20000; n++) begin
      @(negedge clk_sys);
      if (gnt !== 2'b00) begin
        fr_ngnt++;
        if (fr_gnt === 2'b00) fr_gnt = gnt;
        if (drop) req = 2'b00;
      end
      if (rd_en === 1'b1) begin
        fr_rden++;
        if (rd_sel !== exp_sel) fr_selbad++;
      end
      if (spi_ss === 1'b0) begin
        fr_low++;
        if (spi_sck === 1'b1 && prev_sck === 1'b0) begin
          if (fr_bits < WR_BITS) fr_bytes[fr_bits / 8] = {fr_bytes[fr_bits / 8][6:0], spi_do};
          fr_bits++;
        end
      end else if (fr_low > 0) begin
        fr_done = done;
        fr_ok = 1'b1;
        break;
      end else begin
        fr_gap++;
      end
      prev_sck = spi_sck;
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk_sys);
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL %s_idle busy=%b want 0", name, busy); end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk_sys);
    total++; if (spi_ss !== 1'b1) begin bad++; $display("FAIL reset_ss got=%b want=1", spi_ss); end
    total++; if (spi_sck !== 1'b0) begin bad++; $display("FAIL reset_sck got=%b want=0", spi_sck); end
    total++; if (spi_do !== 1'b0) begin bad++; $display("FAIL reset_do got=%b want=0", spi_do); end
    total++; if ({gnt, done} !== 4'b0) begin bad++; $display("FAIL reset_gnt_done got=%b want=0", {gnt, done}); end
    total++; if ({busy, rd_en} !== 2'b0) begin bad++; $display("FAIL reset_busy_rden got=%b want=0", {busy, rd_en}); end
    total++; if (rd_addr !== 8'd0) begin bad++; $display("FAIL reset_rdaddr got=%h want=00", rd_addr); end
    reset_n = 1'b1;
    @(negedge clk_sys);
  endtask

  task automatic test_enable();
    int n;
    op0 = 2'b01; req = 2'b01;
    capture_frame(1'b0, 1'b1);
    total++; if (!fr_ok) begin bad++; $display("FAIL en_frame no frame seen"); end
    total++; if (fr_gnt !== 2'b01 || fr_ngnt != 1) begin bad++; $display("FAIL en_gnt got=%b x%0d want=01 x1", fr_gnt, fr_ngnt); end
    total++; if (fr_low != EN_LOW) begin bad++; $display("FAIL en_ss_low got=%0d want=%0d", fr_low, EN_LOW); end
    total++; if (fr_bits != 8) begin bad++; $display("FAIL en_edges got=%0d want=8", fr_bits); end
    total++; if (fr_bytes[0] !== 8'h41) begin bad++; $display("FAIL en_cmd got=%h want=41", fr_bytes[0]); end
    total++; if (fr_done !== 2'b01) begin bad++; $display("FAIL en_done got=%b want=01", fr_done); end
    total++; if (fr_rden != 0) begin bad++; $display("FAIL en_rden got=%0d want=0", fr_rden); end
    n = 0;
    while (busy === 1'b1 && n < 50) begin
      n++;
      @(negedge clk_sys);
    end
    total++; if (n != SS_GAP) begin bad++; $display("FAIL en_busy_tail got=%0d want=%0d", n, SS_GAP); end
  endtask

  task automatic test_write();
    int errs;
    op1 = 2'b10; line1 = 3'd5; req = 2'b10;
    capture_frame(1'b1, 1'b1);
    total++; if (!fr_ok) begin bad++; $display("FAIL wr_frame no frame seen"); end
    total++; if (fr_gnt !== 2'b10) begin bad++; $display("FAIL wr_gnt got=%b want=10", fr_gnt); end
    total++; if (fr_low != WR_LOW) begin bad++; $display("FAIL wr_ss_low got=%0d want=%0d", fr_low, WR_LOW); end
    total++; if (fr_bits != WR_BITS) begin bad++; $display("FAIL wr_edges got=%0d want=%0d", fr_bits, WR_BITS); end
    total++; if (fr_bytes[0] !== 8'h25) begin bad++; $display("FAIL wr_cmd got=%h want=25", fr_bytes[0]); end
    errs = 0;
    for (int i = 0; i < 256; i++) begin
      if (fr_bytes[i + 1] !== (8'(i) ^ 8'hA5)) begin
        if (errs == 0) $display("FAIL wr_payload byte %0d got=%h want=%h", i, fr_bytes[i + 1], 8'(i) ^ 8'hA5);
        errs++;
      end
    end
    total++; if (errs != 0) bad++;
    total++; if (fr_rden != 256 || fr_selbad != 0) begin bad++; $display("FAIL wr_rden got=%0d selbad=%0d want=256 0", fr_rden, fr_selbad); end
    total++; if (fr_done !== 2'b10) begin bad++; $display("FAIL wr_done got=%b want=10", fr_done); end
    wait_idle("wr");
  endtask

  task automatic test_arbitration();
    logic [1:0] g [0:3];
    int         gp [0:3];
    op0 = 2'b01; op1 = 2'b01; req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      capture_frame((k % 2) == 1, k == 3);
      g[k] = fr_gnt;
      gp[k] = fr_gap;
      total++; if (!fr_ok || fr_bytes[0] !== 8'h41) begin bad++; $display("FAIL arb_frame%0d ok=%b cmd=%h want 1 41", k, fr_ok, fr_bytes[0]); end
    end
    total++;
    if (g[0] !== 2'b01 || g[1] !== 2'b10 || g[2] !== 2'b01 || g[3] !== 2'b10) begin
      bad++; $display("FAIL arb_order got=%b %b %b %b want=01 10 01 10", g[0], g[1], g[2], g[3]);
    end
    for (int k = 1; k < 4; k++) begin
      total++; if (gp[k] + 1 < SS_GAP) begin bad++; $display("FAIL arb_gap%0d got=%0d want>=%0d", k, gp[k] + 1, SS_GAP); end
    end
    wait_idle("arb");
  endtask

  task automatic test_reset_mid();
    int   edges, n, seen;
    logic prev_sck;
    op0 = 2'b10; line0 = 3'd3; req = 2'b01;
    n = 0;
    while (gnt === 2'b00 && n < 20) begin
      n++;
      @(negedge clk_sys);
    end
    req = 2'b00;
    total++; if (gnt !== 2'b01) begin bad++; $display("FAIL rm_gnt got=%b want=01", gnt); end
    edges = 0; prev_sck = 1'b0;
    for (int i = 0; i < 20000 && edges < 8 + 100 * 8 + 4; i++) begin
      @(negedge clk_sys);
      if (spi_sck === 1'b1 && prev_sck === 1'b0) edges++;
      prev_sck = spi_sck;
    end
    total++; if (edges != 8 + 100 * 8 + 4 || spi_ss !== 1'b0) begin bad++; $display("FAIL rm_reach edges=%0d ss=%b want=812 0", edges, spi_ss); end
    reset_n = 1'b0;
    @(negedge clk_sys);
    total++; if ({spi_ss, spi_sck, busy} !== 3'b100) begin bad++; $display("FAIL rm_after ss/sck/busy got=%b want=100", {spi_ss, spi_sck, busy}); end
    total++; if ({done, rd_en} !== 3'b000) begin bad++; $display("FAIL rm_after done/rden got=%b want=000", {done, rd_en}); end
    reset_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk_sys);
      if (done !== 2'b00 || spi_ss !== 1'b1) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL rm_quiet got=%0d events want=0", seen); end
    // Both request after reset; the reset pointer favours requester 0.
    op0 = 2'b01; op1 = 2'b01; req = 2'b11;
    capture_frame(1'b0, 1'b1);
    total++; if (fr_gnt !== 2'b01) begin bad++; $display("FAIL rm_ptr got=%b want=01", fr_gnt); end
    total++; if (fr_low != EN_LOW || fr_bytes[0] !== 8'h41) begin bad++; $display("FAIL rm_frame low=%0d cmd=%h want=%0d 41", fr_low, fr_bytes[0], EN_LOW); end
    total++; if (fr_done !== 2'b01) begin bad++; $display("FAIL rm_done got=%b want=01", fr_done); end
    wait_idle("rm");
  endtask

  task automatic test_clear();
    op0 = 2'b11; line0 = 3'd2; req = 2'b01;
`ifdef OSD_SPI_CLEAR_EN
    begin
      int errs;
      capture_frame(1'b0, 1'b1);
      total++; if (fr_gnt !== 2'b01) begin bad++; $display("FAIL clr_gnt got=%b want=01", fr_gnt); end
      total++; if (fr_bits != WR_BITS || fr_low != WR_LOW) begin bad++; $display("FAIL clr_len bits=%0d low=%0d want=%0d %0d", fr_bits, fr_low, WR_BITS, WR_LOW); end
      total++; if (fr_bytes[0] !== 8'h22) begin bad++; $display("FAIL clr_cmd got=%h want=22", fr_bytes[0]); end
      errs = 0;
      for (int i = 1; i < 257; i++) if (fr_bytes[i] !== 8'h00) errs++;
      total++; if (errs != 0) begin bad++; $display("FAIL clr_zero got=%0d nonzero want=0", errs); end
      total++; if (fr_rden != 0) begin bad++; $display("FAIL clr_rden got=%0d want=0", fr_rden); end
      total++; if (fr_done !== 2'b01) begin bad++; $display("FAIL clr_done got=%b want=01", fr_done); end
      wait_idle("clr");
    end
`else
    begin
      int n, lows;
      n = 0;
      while (gnt === 2'b00 && n < 20) begin
        n++;
        @(negedge clk_sys);
      end
      req = 2'b00;
      total++; if ({gnt, busy, spi_ss} !== 4'b0111) begin bad++; $display("FAIL clr_gnt gnt/busy/ss got=%b want=0111", {gnt, busy, spi_ss}); end
      @(negedge clk_sys);
      total++; if ({done, busy, spi_ss} !== 4'b0111) begin bad++; $display("FAIL clr_done done/busy/ss got=%b want=0111", {done, busy, spi_ss}); end
      @(negedge clk_sys);
      total++; if ({done, busy} !== 3'b000) begin bad++; $display("FAIL clr_end done/busy got=%b want=000", {done, busy}); end
      lows = 0;
      repeat (20) begin
        @(negedge clk_sys);
        if (spi_ss !== 1'b1) lows++;
      end
      total++; if (lows != 0) begin bad++; $display("FAIL clr_ss_low got=%0d want=0", lows); end
    end
`endif
  endtask

  task automatic test_dropped();
    int extra;
    op0 = 2'b01; op1 = 2'b01; req = 2'b10;
    fork
      capture_frame(1'b1, 1'b1);
      begin
        repeat (10) @(negedge clk_sys);
        req[0] = 1'b1;
        @(negedge clk_sys);
        req[0] = 1'b0;
      end
    join
    total++; if (fr_gnt !== 2'b10 || fr_ngnt != 1) begin bad++; $display("FAIL drop_gnt got=%b x%0d want=10 x1", fr_gnt, fr_ngnt); end
    total++; if (fr_bytes[0] !== 8'h41 || fr_done !== 2'b10) begin bad++; $display("FAIL drop_frame cmd=%h done=%b want=41 10", fr_bytes[0], fr_done); end
    extra = 0;
    repeat (40) begin
      @(negedge clk_sys);
      if (gnt !== 2'b00 || spi_ss !== 1'b1) extra++;
    end
    total++; if (extra != 0) begin bad++; $display("FAIL drop_extra got=%0d events want=0", extra); end
  endtask

  initial begin
    test_reset();
    test_enable();
    test_write();
    test_arbitration();
    test_reset_mid();
    test_clear();
    test_dropped();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
